// File: rtl/vinsn_decode_queue_if.sv
// Decode-queue bus: scalar-core offer side plus launcher-facing queue head.
// vop encoding on req_vop: 0 VADD, 1 VSUB, 2 VSLL, 3 VSRL, 4 VSRA, 5 VMERGE, 6 VSE.
// req_vm: 1 = masked, 0 = unmasked. req_use_vs: bit 1 = vs2 read, bit 0 = vs1 read.
interface vinsn_decode_queue_if #(
  parameter int unsigned QueueDepth = 4
);
  localparam int unsigned CntW = $clog2(QueueDepth + 1);

  // Scalar-core side (vec_context is carried as vsew + vle)
  logic            valid;
  logic            ready;
  logic [31:0]     insn;
  logic [3:0]      insn_id;
  logic [1:0]      vsew;
  logic [15:0]     vle;
  logic [63:0]     scalar;
  logic            flush;
  logic            illegal_insn;

  // Launcher side: registered queue head
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_vop;
  logic [1:0]      req_vew;
  logic [18:0]     req_vlb;
  logic [4:0]      req_vs1;
  logic [4:0]      req_vs2;
  logic [4:0]      req_vd;
  logic [1:0]      req_use_vs;
  logic            req_vm;
  logic [63:0]     req_scalar_op;
  logic [3:0]      req_insn_id;
  logic            req_flip_bit;
  logic [CntW-1:0] queue_cnt;

  modport master (
    output valid, insn, insn_id, vsew, vle, scalar, flush, req_ready,
    input  ready, illegal_insn, req_valid, req_vop, req_vew, req_vlb, req_vs1, req_vs2,
           req_vd, req_use_vs, req_vm, req_scalar_op, req_insn_id, req_flip_bit, queue_cnt
  );

  modport slave (
    input  valid, insn, insn_id, vsew, vle, scalar, flush, req_ready,
    output ready, illegal_insn, req_valid, req_vop, req_vew, req_vlb, req_vs1, req_vs2,
           req_vd, req_use_vs, req_vm, req_scalar_op, req_insn_id, req_flip_bit, queue_cnt
  );
endinterface

// File: rtl/vinsn_decode_queue.sv
// Vector instruction decoder feeding a FIFO of decoded issue requests.
// Optional feature macro VINSN_MASK_EN: when defined, masked (vm=0) forms of all ops are
// accepted and the mask flag is forwarded; otherwise only VMERGE may be masked and the
// forwarded vm flag is always unmasked.
module vinsn_decode_queue #(
  parameter int unsigned QueueDepth = 4,
  parameter bit          ScalarOpEn = 1'b1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  vinsn_decode_queue_if.slave dq
);
  localparam int unsigned PtrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned CntW = $clog2(QueueDepth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(QueueDepth);

  localparam logic [6:0] OpcodeVec     = 7'h57;
  localparam logic [6:0] OpcodeStoreFp = 7'h27;
  localparam logic [2:0] F3Opivv       = 3'b000;
  localparam logic [2:0] F3Opivi       = 3'b011;
  localparam logic [2:0] F3Opivx       = 3'b100;
  localparam logic [5:0] F6Vadd        = 6'b000000;
  localparam logic [5:0] F6Vsub        = 6'b000010;
  localparam logic [5:0] F6Vsll        = 6'b100101;
  localparam logic [5:0] F6Vsrl        = 6'b101000;
  localparam logic [5:0] F6Vsra        = 6'b101001;
  localparam logic [5:0] F6Vmerge      = 6'b010111;

  typedef enum logic [2:0] {
    VopVadd, VopVsub, VopVsll, VopVsrl, VopVsra, VopVmerge, VopVse
  } vop_e;

  typedef struct packed {
    vop_e        vop;
    logic [1:0]  vew;
    logic [18:0] vlb;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [1:0]  use_vs;
    logic        vm;
    logic [63:0] scalar_op;
    logic [3:0]  insn_id;
    logic        flip_bit;
  } req_t;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic            flip_q, flip_d;
  req_t            mem_q [QueueDepth];

  req_t dec_req;
  logic dec_illegal;
  logic masked;
  logic ready;
  logic push;
  logic pop;
  logic head_valid;

  // Combinational decode of the offered instruction into a queue entry.
  always_comb begin
    dec_req          = '0;
    dec_illegal      = 1'b0;
    masked           = ~dq.insn[25];
    dec_req.insn_id  = dq.insn_id;
    dec_req.flip_bit = flip_q;
    case (dq.insn[6:0])
      OpcodeVec: begin
        dec_req.vew = dq.vsew;
        dec_req.vlb = {3'b000, dq.vle} << dq.vsew;
        dec_req.vs1 = dq.insn[19:15];
        dec_req.vs2 = dq.insn[24:20];
        dec_req.vd  = dq.insn[11:7];
        case (dq.insn[14:12])
          F3Opivv: dec_req.use_vs = 2'b11;
          F3Opivi: begin
            dec_req.use_vs    = 2'b10;
            dec_req.scalar_op = {{59{dq.insn[19]}}, dq.insn[19:15]};
          end
          F3Opivx: begin
            dec_req.use_vs    = 2'b10;
            dec_req.scalar_op = dq.scalar;
            if (!ScalarOpEn) dec_illegal = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
        case (dq.insn[31:26])
          F6Vadd: dec_req.vop = VopVadd;
          F6Vsub: dec_req.vop = VopVsub;
          F6Vsll: dec_req.vop = VopVsll;
          F6Vsrl: dec_req.vop = VopVsrl;
          F6Vsra: dec_req.vop = VopVsra;
          F6Vmerge: begin
            // Unmasked merge is a plain move: vs2 is not read.
            dec_req.vop       = VopVmerge;
            dec_req.use_vs[1] = masked;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcodeStoreFp: begin
        dec_req.vop    = VopVse;
        dec_req.vs1    = dq.insn[11:7];
        dec_req.use_vs = 2'b01;
        case ({dq.insn[28], dq.insn[14:12]})
          4'b0000: dec_req.vew = 2'd0;
          4'b0101: dec_req.vew = 2'd1;
          4'b0110: dec_req.vew = 2'd2;
          4'b0111: dec_req.vew = 2'd3;
          default: dec_illegal = 1'b1;
        endcase
        dec_req.vlb = {3'b000, dq.vle} << dec_req.vew;
      end
      default: dec_illegal = 1'b1;
    endcase
`ifdef VINSN_MASK_EN
    dec_req.vm = masked;
`else
    dec_req.vm = 1'b0;
    if (masked && !(dq.insn[6:0] == OpcodeVec && dq.insn[31:26] == F6Vmerge)) begin
      dec_illegal = 1'b1;
    end
`endif
  end

  // Handshake: a pop frees a slot for a same-cycle push, flush blocks everything.
  always_comb begin
    head_valid = (cnt_q != '0);
    ready      = !rst_i && !dq.flush && ((cnt_q < DepthCnt) || (head_valid && dq.req_ready));
    push       = dq.valid && ready && !dec_illegal;
    pop        = head_valid && dq.req_ready && !dq.flush;
  end

  // Next-state for occupancy, pointers and flip bit.
  always_comb begin
    cnt_d  = cnt_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    flip_d = flip_q;
    if (dq.flush) begin
      cnt_d  = '0;
      rptr_d = '0;
      wptr_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PtrW'(1);
        flip_d = ~flip_q;
      end
      if (pop) rptr_d = rptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CntW'(1);
        2'b01:   cnt_d = cnt_q - CntW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      flip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      flip_q <= flip_d;
    end
  end

  // Entry storage, deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= dec_req;
  end

  assign dq.ready         = ready;
  assign dq.illegal_insn  = dq.valid && ready && dec_illegal;
  assign dq.req_valid     = head_valid;
  assign dq.queue_cnt     = cnt_q;
  assign dq.req_vop       = mem_q[rptr_q].vop;
  assign dq.req_vew       = mem_q[rptr_q].vew;
  assign dq.req_vlb       = mem_q[rptr_q].vlb;
  assign dq.req_vs1       = mem_q[rptr_q].vs1;
  assign dq.req_vs2       = mem_q[rptr_q].vs2;
  assign dq.req_vd        = mem_q[rptr_q].vd;
  assign dq.req_use_vs    = mem_q[rptr_q].use_vs;
  assign dq.req_vm        = mem_q[rptr_q].vm;
  assign dq.req_scalar_op = mem_q[rptr_q].scalar_op;
  assign dq.req_insn_id   = mem_q[rptr_q].insn_id;
  assign dq.req_flip_bit  = mem_q[rptr_q].flip_bit;
endmodule

// File: tb/tb_vinsn_decode_queue.sv
// Scoreboard bench for vinsn_decode_queue (QueueDepth=4, ScalarOpEn=1).
module tb_vinsn_decode_queue;
  localparam int Depth = 4;

  typedef struct packed {
    logic [2:0]  vop;
    logic [1:0]  vew;
    logic [18:0] vlb;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [4:0]  vd;
    logic [1:0]  use_vs;
    logic        vm;
    logic [63:0] scalar_op;
    logic [3:0]  insn_id;
    logic        flip_bit;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vinsn_decode_queue_if #(.QueueDepth(Depth)) dq_if ();

  vinsn_decode_queue #(.QueueDepth(Depth), .ScalarOpEn(1'b1)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .dq   (dq_if)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   cnt_m = 0;
  bit   flip_m = 1'b0;
  logic [3:0] id_m = 4'd0;

  logic o_ready, o_illegal, o_rvalid;
  logic [2:0] o_cnt;
  exp_t o_head;
  logic e_ready, e_illegal, e_rvalid, e_pop;
  int   e_cnt;
  exp_t e_head;

  function automatic logic [31:0] enc_v(input logic [5:0] f6, input logic vm,
      input logic [4:0] vs2, input logic [4:0] vs1, input logic [2:0] f3, input logic [4:0] vd);
    return {f6, vm, vs2, vs1, f3, vd, 7'h57};
  endfunction

  function automatic logic [31:0] enc_st(input logic [3:0] mw, input logic vm,
      input logic [4:0] rs1, input logic [4:0] vs3);
    return {3'b000, mw[3], 2'b00, vm, 5'b00000, rs1, mw[2:0], vs3, 7'h27};
  endfunction

  // Reference decoder.
  function automatic void model_dec(input logic [31:0] w, input logic [3:0] id,
      input logic [1:0] sew, input logic [15:0] vle, input logic [63:0] sc, input bit flip,
      output exp_t r, output bit bad);
    bit msk;
    logic signed [63:0] simm;
    logic [3:0] key;
    r = '0;
    bad = 1'b0;
    msk = (w[25] == 1'b0);
    r.insn_id = id;
    r.flip_bit = flip;
    if (w[6:0] == 7'h57) begin
      r.vew = sew;
      r.vlb = 19'(32'(vle) * (32'd1 << sew));
      r.vs2 = w[24:20];
      r.vs1 = w[19:15];
      r.vd  = w[11:7];
      if (w[14:12] == 3'd0) r.use_vs = 2'd3;
      else if (w[14:12] == 3'd3) begin
        r.use_vs = 2'd2;
        simm = $signed(w[19:15]);
        r.scalar_op = simm;
      end else if (w[14:12] == 3'd4) begin
        r.use_vs = 2'd2;
        r.scalar_op = sc;
      end else bad = 1'b1;
      case (w[31:26])
        6'd0:  r.vop = 3'd0;
        6'd2:  r.vop = 3'd1;
        6'd37: r.vop = 3'd2;
        6'd40: r.vop = 3'd3;
        6'd41: r.vop = 3'd4;
        6'd23: begin r.vop = 3'd5; r.use_vs[1] = msk; end
        default: bad = 1'b1;
      endcase
    end else if (w[6:0] == 7'h27) begin
      r.vop = 3'd6;
      r.vs1 = w[11:7];
      r.use_vs = 2'd1;
      key = {w[28], w[14:12]};
      if (key == 4'd0) r.vew = 2'd0;
      else if (key == 4'd5) r.vew = 2'd1;
      else if (key == 4'd6) r.vew = 2'd2;
      else if (key == 4'd7) r.vew = 2'd3;
      else bad = 1'b1;
      r.vlb = 19'(32'(vle) * (32'd1 << r.vew));
    end else bad = 1'b1;
`ifdef VINSN_MASK_EN
    r.vm = msk;
`else
    if (msk && !(w[6:0] == 7'h57 && w[31:26] == 6'd23)) bad = 1'b1;
`endif
  endfunction

  // One clock of stimulus: drives inputs, samples DUT before the edge, advances the model.
  task automatic drive_cycle(input bit v, input logic [31:0] w, input logic [1:0] sew,
      input logic [15:0] vle, input logic [63:0] sc, input bit rr, input bit fl);
    exp_t r;
    bit bad;
    dq_if.valid = v;
    dq_if.insn = w;
    dq_if.insn_id = id_m;
    dq_if.vsew = sew;
    dq_if.vle = vle;
    dq_if.scalar = sc;
    dq_if.req_ready = rr;
    dq_if.flush = fl;
    model_dec(w, id_m, sew, vle, sc, flip_m, r, bad);
    e_cnt = cnt_m;
    e_rvalid = (cnt_m != 0);
    e_ready = !fl && (cnt_m < Depth || (e_rvalid && rr));
    e_illegal = v && e_ready && bad;
    e_pop = e_rvalid && rr && !fl;
    #3;
    o_ready = dq_if.ready;
    o_illegal = dq_if.illegal_insn;
    o_rvalid = dq_if.req_valid;
    o_cnt = dq_if.queue_cnt;
    o_head = {dq_if.req_vop, dq_if.req_vew, dq_if.req_vlb, dq_if.req_vs1, dq_if.req_vs2,
              dq_if.req_vd, dq_if.req_use_vs, dq_if.req_vm, dq_if.req_scalar_op,
              dq_if.req_insn_id, dq_if.req_flip_bit};
    if (e_pop && sb.size() > 0) e_head = sb.pop_front();
    if (fl) begin
      sb.delete();
      cnt_m = 0;
    end else begin
      if (v && e_ready && !bad) begin
        sb.push_back(r);
        flip_m = !flip_m;
        cnt_m++;
      end
      if (e_pop) cnt_m--;
    end
    @(posedge clk);
    #1;
    id_m = id_m + 4'd1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    dq_if.valid = 1'b0;
    dq_if.flush = 1'b0;
    dq_if.req_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    cnt_m = 0;
    flip_m = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dq_if.valid = 1'b1;
    dq_if.insn = enc_v(6'd0, 1'b1, 5'd2, 5'd1, 3'd0, 5'd3);
    dq_if.insn_id = 4'd0;
    dq_if.vsew = 2'd0;
    dq_if.vle = 16'd1;
    dq_if.scalar = 64'd0;
    dq_if.flush = 1'b0;
    dq_if.req_ready = 1'b0;
    @(posedge clk);
    #4;
    checks++;
    if (dq_if.ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", dq_if.ready);
    end
    checks++;
    if (dq_if.illegal_insn !== 1'b0) begin
      errors++; $display("FAIL reset_illegal got %b exp 0", dq_if.illegal_insn);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    dq_if.valid = 1'b0;
    checks++;
    if (dq_if.queue_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_cnt got %0d exp 0", dq_if.queue_cnt);
    end
    checks++;
    if (dq_if.req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid got %b exp 0", dq_if.req_valid);
    end
    sb.delete();
    cnt_m = 0;
    flip_m = 1'b0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20 && cnt_m > 0; i++) begin
      drive_cycle(1'b0, 32'd0, 2'd0, 16'd0, 64'd0, 1'b1, 1'b0);
      checks++;
      if (o_rvalid !== e_rvalid) begin
        errors++; $display("FAIL drain_req_valid got %b exp %b", o_rvalid, e_rvalid);
      end
      if (e_pop) begin
        checks++;
        if (o_head !== e_head) begin
          errors++; $display("FAIL drain_head got %h exp %h", o_head, e_head);
        end
      end
    end
    checks++;
    if (cnt_m != 0 || dq_if.queue_cnt !== 3'd0) begin
      errors++; $display("FAIL drain_empty got %0d exp 0", dq_if.queue_cnt);
    end
  endtask

  task automatic test_vadd_vv();
    apply_reset();
    drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'd2, 5'd1, 3'd0, 5'd3), 2'd2, 16'd8, 64'd0, 1'b0,
                1'b0);
    checks++;
    if (o_ready !== 1'b1 || o_illegal !== 1'b0) begin
      errors++; $display("FAIL vadd_accept got rdy %b ill %b exp 1 0", o_ready, o_illegal);
    end
    checks++;
    if (o_rvalid !== 1'b0) begin
      errors++; $display("FAIL vadd_no_bypass got %b exp 0", o_rvalid);
    end
    drive_cycle(1'b0, 32'd0, 2'd0, 16'd0, 64'd0, 1'b1, 1'b0);
    checks++;
    if (o_rvalid !== 1'b1) begin
      errors++; $display("FAIL vadd_req_valid got %b exp 1", o_rvalid);
    end
    checks++;
    if (o_head !== e_head) begin
      errors++; $display("FAIL vadd_head got %h exp %h", o_head, e_head);
    end
    checks++;
    if (o_head.vop !== 3'd0 || o_head.vlb !== 19'd32 || o_head.use_vs !== 2'b11 ||
        o_head.flip_bit !== 1'b0) begin
      errors++;
      $display("FAIL vadd_fields got vop %0d vlb %0d use %b flip %b exp 0 32 11 0",
               o_head.vop, o_head.vlb, o_head.use_vs, o_head.flip_bit);
    end
  endtask

  task automatic test_full();
    logic [31:0] tbl [5];
    apply_reset();
    tbl[0] = enc_v(6'd2, 1'b1, 5'd4, 5'd9, 3'd4, 5'd5);
    tbl[1] = enc_v(6'd37, 1'b1, 5'd6, 5'd5, 3'd3, 5'd7);
    tbl[2] = enc_v(6'd40, 1'b1, 5'd8, 5'd1, 3'd0, 5'd9);
    tbl[3] = enc_v(6'd41, 1'b1, 5'd10, 5'd2, 3'd0, 5'd11);
    tbl[4] = enc_v(6'd0, 1'b1, 5'd12, 5'd3, 3'd0, 5'd13);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, tbl[i], 2'(i), 16'(i + 1), 64'hDEAD_0000 + 64'(i), 1'b0, 1'b0);
      checks++;
      if (o_ready !== e_ready) begin
        errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, o_ready, e_ready);
      end
    end
    checks++;
    if (dq_if.queue_cnt !== 3'd4 || o_ready !== 1'b0) begin
      errors++; $display("FAIL full_cnt got %0d rdy %b exp 4 0", dq_if.queue_cnt, o_ready);
    end
    // Full queue: push and pop in the same cycle.
    drive_cycle(1'b1, enc_v(6'd23, 1'b0, 5'd1, 5'd2, 3'd0, 5'd3), 2'd1, 16'd4, 64'd0, 1'b1,
                1'b0);
    checks++;
    if (o_ready !== 1'b1 || o_illegal !== 1'b0) begin
      errors++; $display("FAIL full_pushpop_rdy got %b %b exp 1 0", o_ready, o_illegal);
    end
    checks++;
    if (o_head !== e_head) begin
      errors++; $display("FAIL full_pushpop_head got %h exp %h", o_head, e_head);
    end
    checks++;
    if (dq_if.queue_cnt !== 3'd4) begin
      errors++; $display("FAIL full_pushpop_cnt got %0d exp 4", dq_if.queue_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad_tbl [6];
    int cnt0;
    bit flip0;
    bad_tbl[0] = enc_st(4'b0001, 1'b1, 5'd1, 5'd2);
    bad_tbl[1] = 32'h0000_0033;
    bad_tbl[2] = enc_v(6'd0, 1'b1, 5'd1, 5'd1, 3'd1, 5'd1);
    bad_tbl[3] = enc_v(6'b111111, 1'b1, 5'd1, 5'd1, 3'd0, 5'd1);
    bad_tbl[4] = enc_st(4'b0100, 1'b1, 5'd1, 5'd2);
    bad_tbl[5] = enc_st(4'b1101, 1'b1, 5'd1, 5'd2);
    cnt0 = cnt_m;
    flip0 = flip_m;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, bad_tbl[i], 2'd1, 16'd3, 64'd0, 1'b0, 1'b0);
      checks++;
      if (o_illegal !== 1'b1 || e_illegal !== 1'b1) begin
        errors++; $display("FAIL illegal[%0d] got %b exp 1", i, o_illegal);
      end
    end
    checks++;
    if (dq_if.queue_cnt !== 3'(cnt0) || flip_m != flip0) begin
      errors++; $display("FAIL illegal_cnt got %0d exp %0d", dq_if.queue_cnt, cnt0);
    end
    // Legal unit-stride stores, one with vle == 0.
    drive_cycle(1'b1, enc_st(4'b0000, 1'b1, 5'd3, 5'd4), 2'd3, 16'd0, 64'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, enc_st(4'b0101, 1'b1, 5'd3, 5'd5), 2'd0, 16'd5, 64'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, enc_st(4'b0110, 1'b1, 5'd3, 5'd6), 2'd0, 16'd5, 64'd0, 1'b1, 1'b0);
    checks++;
    if (o_head.flip_bit !== flip0 || o_head.vop !== 3'd6 || o_head.vlb !== 19'd0) begin
      errors++;
      $display("FAIL store_vle0 got flip %b vop %0d vlb %0d exp %b 6 0", o_head.flip_bit,
               o_head.vop, o_head.vlb, flip0);
    end
    drive_cycle(1'b1, enc_st(4'b0111, 1'b1, 5'd3, 5'd7), 2'd0, 16'd2, 64'd0, 1'b0, 1'b0);
    checks++;
    if (o_illegal !== 1'b0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL store_ew64 got ill %b rdy %b exp 0 1", o_illegal, o_ready);
    end
  endtask

  task automatic test_flush();
    bit flip0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'(i), 5'd1, 3'd0, 5'd2), 2'd0, 16'd1, 64'd0, 1'b0,
                  1'b0);
    end
    flip0 = flip_m;
    drive_cycle(1'b1, enc_st(4'b0001, 1'b1, 5'd1, 5'd1), 2'd0, 16'd1, 64'd0, 1'b1, 1'b1);
    checks++;
    if (o_ready !== 1'b0 || o_illegal !== 1'b0) begin
      errors++; $display("FAIL flush_rdy_ill got %b %b exp 0 0", o_ready, o_illegal);
    end
    checks++;
    if (dq_if.queue_cnt !== 3'd0 || dq_if.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty got cnt %0d vld %b exp 0 0", dq_if.queue_cnt, dq_if.req_valid);
    end
    drive_cycle(1'b1, enc_v(6'd2, 1'b1, 5'd3, 5'd4, 3'd0, 5'd5), 2'd1, 16'd2, 64'd0, 1'b0,
                1'b0);
    drive_cycle(1'b0, 32'd0, 2'd0, 16'd0, 64'd0, 1'b1, 1'b0);
    checks++;
    if (o_head.flip_bit !== flip0 || o_head !== e_head) begin
      errors++; $display("FAIL flush_flip got %b exp %b", o_head.flip_bit, flip0);
    end
  endtask

  task automatic test_scalar_mask();
    bit exp_bad;
    apply_reset();
    drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'd2, 5'b11101, 3'd3, 5'd3), 2'd0, 16'd4, 64'd0, 1'b0,
                1'b0);
    drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'd2, 5'd7, 3'd4, 5'd3), 2'd3, 16'd4,
                64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    checks++;
    if (o_head.scalar_op !== 64'hFFFF_FFFF_FFFF_FFFD || o_head.use_vs !== 2'b10) begin
      errors++; $display("FAIL vi_simm got %h exp fffffffffffffffd", o_head.scalar_op);
    end
`ifdef VINSN_MASK_EN
    exp_bad = 1'b0;
`else
    exp_bad = 1'b1;
`endif
    drive_cycle(1'b1, enc_v(6'd0, 1'b0, 5'd2, 5'd1, 3'd0, 5'd3), 2'd0, 16'd4, 64'd0, 1'b1,
                1'b0);
    checks++;
    if (o_illegal !== exp_bad) begin
      errors++; $display("FAIL masked_vadd got %b exp %b", o_illegal, exp_bad);
    end
    checks++;
    if (o_head !== e_head) begin
      errors++; $display("FAIL vx_head got %h exp %h", o_head, e_head);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [8];
    int k;
    tbl[0] = enc_v(6'd0, 1'b1, 5'd1, 5'd2, 3'd0, 5'd3);
    tbl[1] = enc_v(6'd2, 1'b1, 5'd4, 5'd5, 3'd4, 5'd6);
    tbl[2] = enc_v(6'd41, 1'b1, 5'd7, 5'b10000, 3'd3, 5'd8);
    tbl[3] = enc_v(6'd23, 1'b1, 5'd0, 5'd9, 3'd4, 5'd10);
    tbl[4] = enc_st(4'b0110, 1'b1, 5'd1, 5'd11);
    tbl[5] = enc_v(6'd37, 1'b0, 5'd1, 5'd2, 3'd0, 5'd3);
    tbl[6] = 32'h0000_0013;
    tbl[7] = enc_v(6'd40, 1'b1, 5'd12, 5'd13, 3'd2, 5'd14);
    for (int i = 0; i < 48; i++) begin
      k = int'($urandom_range(0, 7));
      drive_cycle($urandom_range(0, 3) != 0, tbl[k], 2'($urandom_range(0, 3)),
                  16'($urandom_range(0, 64)), {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  1'b0);
      checks++;
      if (o_ready !== e_ready || o_illegal !== e_illegal || o_rvalid !== e_rvalid ||
          o_cnt !== 3'(e_cnt)) begin
        errors++;
        $display("FAIL b2b_ctrl[%0d] got %b%b%b cnt %0d exp %b%b%b cnt %0d", i, o_ready,
                 o_illegal, o_rvalid, o_cnt, e_ready, e_illegal, e_rvalid, e_cnt);
      end
      if (e_pop) begin
        checks++;
        if (o_head !== e_head) begin
          errors++; $display("FAIL b2b_head[%0d] got %h exp %h", i, o_head, e_head);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'd1, 5'd1, 3'd0, 5'd1), 2'd0, 16'd1, 64'd0, 1'b0,
                1'b0);
    drive_cycle(1'b1, enc_v(6'd0, 1'b1, 5'd2, 5'd2, 3'd0, 5'd2), 2'd0, 16'd1, 64'd0, 1'b0,
                1'b0);
    dq_if.req_ready = 1'b1;
    apply_reset();
    checks++;
    if (dq_if.queue_cnt !== 3'd0 || dq_if.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got cnt %0d vld %b exp 0 0", dq_if.queue_cnt, dq_if.req_valid);
    end
    drive_cycle(1'b1, enc_v(6'd2, 1'b1, 5'd3, 5'd3, 3'd0, 5'd3), 2'd0, 16'd2, 64'd0, 1'b0,
                1'b0);
    drive_cycle(1'b0, 32'd0, 2'd0, 16'd0, 64'd0, 1'b1, 1'b0);
    checks++;
    if (o_head !== e_head || o_head.flip_bit !== 1'b0) begin
      errors++; $display("FAIL reset_mid_head got %h exp %h", o_head, e_head);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vadd_vv();
    test_drain();
    test_full();
    test_drain();
    test_illegal();
    test_drain();
    test_flush();
    test_drain();
    test_scalar_mask();
    test_drain();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
